// File: rtl/i2s_master_tx.sv
// ============================================================================
// i2s_master_tx
// ----------------------------------------------------------------------------
// I2S master transmitter. Takes a parallel left/right sample pair through a
// single-entry holding register (rdy/wrt handshake) and serialises it as a
// standard I2S frame: SCLK = clk/(2*SCLK_HALF), WS low for the left word and
// high for the right word, data MSB first with the one-SCLK I2S delay. Data
// and WS only change on SCLK falling events, so a receiver samples on SCLK
// rising edges.
//
// Parameters
//   DATA_W     bits per channel; one frame is 2*DATA_W SCLK periods
//   SCLK_HALF  clk cycles per SCLK half period (must be >= 4)
//
// Ports
//   clk         in   system clock, all logic on posedge
//   rst         in   asynchronous reset, active high
//   en          in   start/continue; looked at only on frame boundaries
//   lft_chnnl   in   left sample (two's complement)
//   rght_chnnl  in   right sample (two's complement)
//   wrt         in   load both channels into holding reg (only when rdy=1)
//   clr_undrn   in   clear the sticky underrun flag
//   rdy         out  holding register empty
//   frm_strt    out  1-clk pulse when a frame word is captured (p=0)
//   undrn       out  sticky: a frame started with the holding reg empty
//   I2S_sclk    out  serial clock (flop)
//   I2S_ws      out  word select, 0=left 1=right (flop)
//   I2S_data    out  serial data, MSB first (flop)
//
// Build option
//   I2S_TX_UNDERRUN_REPEAT_EN  defined:   an underrun frame repeats the last
//                                         successfully captured word
//                              undefined: an underrun frame sends all zeros
// ============================================================================
module i2s_master_tx #(
  parameter int DATA_W    = 24,
  parameter int SCLK_HALF = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] lft_chnnl,
  input  logic [DATA_W-1:0] rght_chnnl,
  input  logic              wrt,
  input  logic              clr_undrn,
  output logic              rdy,
  output logic              frm_strt,
  output logic              undrn,
  output logic              I2S_sclk,
  output logic              I2S_ws,
  output logic              I2S_data
);

  localparam int FRM_W = 2 * DATA_W;
  localparam int POS_W = $clog2(FRM_W);
  localparam int DIV_W = $clog2(SCLK_HALF);

  localparam logic [DIV_W-1:0] DIV_TC    = DIV_W'(SCLK_HALF - 1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(FRM_W - 1);
  localparam logic [POS_W-1:0] POS_RIGHT = POS_W'(DATA_W);

  // Elaboration-time guard: the divider needs room for a sensible half period.
  generate
    if (SCLK_HALF < 4) begin : g_bad_sclk_half
      $error("i2s_master_tx: SCLK_HALF must be >= 4");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_go;
  logic               w_stop;

  logic               r_start;      // first clk in RUN: the p=0 fall event
  logic [DIV_W-1:0]   r_div;
  logic [POS_W-1:0]   r_pos;
  logic [FRM_W-1:0]   r_shift;
  logic               r_sclk;
  logic               r_ws;
  logic               r_data;

  logic               r_rdy;
  logic [DATA_W-1:0]  r_hold_l;
  logic [DATA_W-1:0]  r_hold_r;
  logic               r_frm_strt;
  logic               r_undrn;

  logic               w_run;
  logic               w_tc;
  logic               w_fall;
  logic               w_rise;
  logic               w_p0;
  logic               w_cap;
  logic               w_undrn_evt;
  logic [POS_W-1:0]   w_pos_nxt;
  logic [FRM_W-1:0]   w_fallback;
  logic [FRM_W-1:0]   w_cap_word;

  // SCLK event decode. The very first fall after leaving IDLE is synthetic:
  // SCLK is already low, but the frame position still starts there.
  assign w_run  = (r_state == ST_RUN);
  assign w_tc   = (r_div == DIV_TC);
  assign w_fall = w_run && (r_start || (w_tc && r_sclk));
  assign w_rise = w_run && !r_start && w_tc && !r_sclk;

  // p=0 is reached either on the synthetic first fall or on wrap-around.
  assign w_p0      = w_fall && (r_start || (r_pos == POS_LAST));
  assign w_cap     = w_p0 && !w_stop;
  assign w_pos_nxt = w_p0 ? {POS_W{1'b0}} : (r_pos + POS_W'(1));

  // A capture finding the holding register empty is an underrun.
  assign w_undrn_evt = w_cap && r_rdy;
  assign w_cap_word  = r_rdy ? w_fallback : {r_hold_l, r_hold_r};

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  logic [FRM_W-1:0] r_last;

  // Remember the last word that came from the holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= {FRM_W{1'b0}};
    end else if (w_cap && !r_rdy) begin
      r_last <= {r_hold_l, r_hold_r};
    end else begin
      r_last <= r_last;
    end
  end

  assign w_fallback = r_last;
`else
  assign w_fallback = {FRM_W{1'b0}};
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: en only matters in IDLE and at the frame wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_stop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = ST_RUN;
          w_go        = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_fall && !r_start && (r_pos == POS_LAST) && !en) begin
          w_state_nxt = ST_IDLE;
          w_stop      = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Divider, frame position, shifter and the three I2S pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start <= 1'b0;
      r_div   <= {DIV_W{1'b0}};
      r_pos   <= {POS_W{1'b0}};
      r_shift <= {FRM_W{1'b0}};
      r_sclk  <= 1'b0;
      r_ws    <= 1'b1;
      r_data  <= 1'b0;
    end else begin
      r_start <= w_go;
      if (!w_run || w_stop) begin
        // Idle line state; the shifter is cleared so the next first p=0 bit is 0.
        r_div   <= {DIV_W{1'b0}};
        r_pos   <= {POS_W{1'b0}};
        r_shift <= {FRM_W{1'b0}};
        r_sclk  <= 1'b0;
        r_ws    <= 1'b1;
        r_data  <= 1'b0;
      end else begin
        if (w_fall || w_rise) begin
          r_div <= {DIV_W{1'b0}};
        end else begin
          r_div <= r_div + DIV_W'(1);
        end

        if (w_rise) begin
          r_sclk <= 1'b1;
        end else if (w_fall) begin
          r_sclk <= 1'b0;
        end else begin
          r_sclk <= r_sclk;
        end

        // The shifter MSB always holds the bit due on this fall; at p=0 that
        // is the previous frame's right LSB, giving the one-SCLK I2S delay.
        if (w_fall) begin
          r_pos  <= w_pos_nxt;
          r_ws   <= (w_pos_nxt >= POS_RIGHT);
          r_data <= r_shift[FRM_W-1];
          if (w_cap) begin
            r_shift <= w_cap_word;
          end else begin
            r_shift <= {r_shift[FRM_W-2:0], 1'b0};
          end
        end else begin
          r_pos   <= r_pos;
          r_ws    <= r_ws;
          r_data  <= r_data;
          r_shift <= r_shift;
        end
      end
    end
  end

  // Holding register and rdy handshake. A capture with a full register
  // empties it; a write is only accepted while empty, which also covers a
  // write landing on an underrun capture (it fills the next frame).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy    <= 1'b1;
      r_hold_l <= {DATA_W{1'b0}};
      r_hold_r <= {DATA_W{1'b0}};
    end else if (w_cap && !r_rdy) begin
      r_rdy    <= 1'b1;
      r_hold_l <= r_hold_l;
      r_hold_r <= r_hold_r;
    end else if (wrt && r_rdy) begin
      r_rdy    <= 1'b0;
      r_hold_l <= lft_chnnl;
      r_hold_r <= rght_chnnl;
    end else begin
      r_rdy    <= r_rdy;
      r_hold_l <= r_hold_l;
      r_hold_r <= r_hold_r;
    end
  end

  // Frame-start pulse and sticky underrun flag (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frm_strt <= 1'b0;
      r_undrn    <= 1'b0;
    end else begin
      r_frm_strt <= w_cap;
      if (w_undrn_evt) begin
        r_undrn <= 1'b1;
      end else if (clr_undrn) begin
        r_undrn <= 1'b0;
      end else begin
        r_undrn <= r_undrn;
      end
    end
  end

  assign rdy      = r_rdy;
  assign frm_strt = r_frm_strt;
  assign undrn    = r_undrn;
  assign I2S_sclk = r_sclk;
  assign I2S_ws   = r_ws;
  assign I2S_data = r_data;

endmodule

// File: tb/tb_i2s_master_tx.sv
// ============================================================================
// tb_i2s_master_tx
// Directed bench for i2s_master_tx (DATA_W=24, SCLK_HALF=4). Frames are
// collected at every SCLK fall and compared against hand-computed words; a
// small I2S receiver sampling on SCLK rise acts as the loopback slave.
// ============================================================================
module tb_i2s_master_tx;

  localparam int DW   = 24;
  localparam int HALF = 4;

  localparam logic [47:0] W1     = 48'hA50F3C5AF0C3;
  localparam logic [47:0] W4     = 48'h12345689ABCD;
  localparam logic [47:0] W5     = 48'h8000017FFFFE;
  localparam logic [47:0] WS_PAT = 48'h000001FFFFFE;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  localparam logic [47:0] FB     = W1;
`else
  localparam logic [47:0] FB     = 48'h000000000000;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          wrt;
  logic          clr_undrn;
  logic [DW-1:0] lft;
  logic [DW-1:0] rght;
  logic          rdy;
  logic          frm_strt;
  logic          undrn;
  logic          I2S_sclk;
  logic          I2S_ws;
  logic          I2S_data;
  logic [5:0]    w_outs;

  int n_chk  = 0;
  int n_pass = 0;

  i2s_master_tx #(.DATA_W(DW), .SCLK_HALF(HALF)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lft_chnnl  (lft),
    .rght_chnnl (rght),
    .wrt        (wrt),
    .clr_undrn  (clr_undrn),
    .rdy        (rdy),
    .frm_strt   (frm_strt),
    .undrn      (undrn),
    .I2S_sclk   (I2S_sclk),
    .I2S_ws     (I2S_ws),
    .I2S_data   (I2S_data)
  );

  always #5 clk = ~clk;

  assign w_outs = {I2S_sclk, I2S_ws, I2S_data, rdy, frm_strt, undrn};

  // Loopback receiver: word completes on the rise where WS goes 1->0.
  logic [47:0] rx_sr;
  int          rx_cnt;
  logic        rx_ws_prev;
  logic [47:0] rx_q[$];

  always @(posedge I2S_sclk or posedge rst) begin
    if (rst) begin
      rx_sr      <= 48'd0;
      rx_cnt     <= 0;
      rx_ws_prev <= 1'b1;
      rx_q.delete();
    end else begin
      rx_sr      <= {rx_sr[46:0], I2S_data};
      rx_ws_prev <= I2S_ws;
      if (rx_ws_prev && !I2S_ws) begin
        if (rx_cnt == 47) rx_q.push_back({rx_sr[46:0], I2S_data});
        rx_cnt <= 0;
      end else begin
        rx_cnt <= rx_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Collect 48 SCLK falls. Optionally issue wrt on the clk of the 48th fall.
  task automatic frame(input logic wr_last, input logic [DW-1:0] wl, input logic [DW-1:0] wr,
                       input string tag, output logic [47:0] bits, output logic [47:0] wsv);
    int   nf = 0, since = 0, since_sc = 0, nsc = 0, bad_half = 0, bad_chg = 0, guard = 0;
    logic p_sclk, p_ws, p_data;
    bits   = 48'd0;
    wsv    = 48'd0;
    p_sclk = I2S_sclk;
    p_ws   = I2S_ws;
    p_data = I2S_data;
    while (nf < 48 && guard < 600) begin
      if (wr_last && nf == 47 && since == 2 * HALF - 1) begin
        wrt  = 1'b1;
        lft  = wl;
        rght = wr;
      end
      tick();
      wrt = 1'b0;
      guard++;
      since++;
      since_sc++;
      if (I2S_sclk != p_sclk) begin
        if (nsc > 0 && since_sc != HALF) bad_half++;
        nsc++;
        since_sc = 0;
      end
      if (p_sclk && !I2S_sclk) begin
        nf++;
        since = 0;
        bits  = {bits[46:0], I2S_data};
        wsv   = {wsv[46:0], I2S_ws};
      end else if (I2S_ws != p_ws || I2S_data != p_data) begin
        bad_chg++;
      end
      p_sclk = I2S_sclk;
      p_ws   = I2S_ws;
      p_data = I2S_data;
    end
    check({tag, "_len"}, 48'(nf), 48'd48);
    check({tag, "_half"}, 48'(bad_half), 48'd0);
    check({tag, "_chg_off_fall"}, 48'(bad_chg), 48'd0);
  endtask

  initial begin
    logic [47:0] b;
    logic [47:0] w;
    int          rises;
    rst = 1'b1; en = 1'b0; wrt = 1'b0; clr_undrn = 1'b0; lft = '0; rght = '0;
    repeat (3) tick();
    check("rst_vals", 48'(w_outs), 48'(6'b010100));

    // Reset in the middle of a running frame (SCLK high, WS low, undrn set).
    rst = 1'b0;
    tick();
    en = 1'b1;
    repeat (30) tick();
    check("pre_rst", 48'({I2S_sclk, I2S_ws, undrn}), 48'(3'b101));
    rst = 1'b1;
    #1;
    check("rst_mid", 48'(w_outs), 48'(6'b010100));
    en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Load a pair while idle, then start.
    lft = 24'hA50F3C; rght = 24'h5AF0C3; wrt = 1'b1;
    tick();
    wrt = 1'b0;
    check("wrt_rdy", 48'(rdy), 48'd0);
    en = 1'b1;
    tick();
    check("run_wait", 48'(w_outs), 48'(6'b010000));
    tick();
    check("p0_first", 48'(w_outs), 48'(6'b000110));

    frame(1'b0, '0, '0, "f1", b, w);
    check("f1_data", b, W1);
    check("f1_ws", w, WS_PAT);
    check("undrn_set", 48'({rdy, frm_strt, undrn}), 48'(3'b111));
    clr_undrn = 1'b1;
    tick();
    clr_undrn = 1'b0;
    check("undrn_clr", 48'(undrn), 48'd0);

    // Frame 2 is an underrun; a write lands on the frame-3 capture clk.
    frame(1'b1, 24'h123456, 24'h89ABCD, "f2", b, w);
    check("f2_data", b, FB);
    check("sim_wrt", 48'({rdy, frm_strt, undrn}), 48'(3'b011));
    lft = 24'hFFFFFF; rght = 24'h000001; wrt = 1'b1;
    tick();
    wrt = 1'b0;
    check("wrt_ignored", 48'(rdy), 48'd0);
    frame(1'b0, '0, '0, "f3", b, w);
    check("f3_data", b, FB);
    check("f4_p0", 48'({rdy, frm_strt, undrn}), 48'(3'b111));

    // Drop en mid-frame: frame 4 runs to its end, then IDLE.
    repeat (5) tick();
    en = 1'b0;
    frame(1'b0, '0, '0, "f4", b, w);
    check("f4_data", 48'(b[47:1]), 48'(W4[47:1]));
    check("f4_ws", 48'(w[47:1]), 48'(WS_PAT[47:1]));
    check("f4_stop", 48'(w_outs), 48'(6'b010101));
    rises = 0;
    repeat (20) begin
      tick();
      if (I2S_sclk || !I2S_ws || I2S_data) rises++;
    end
    check("idle_hold", 48'(rises), 48'd0);

    // Restart: first p=0 bit must be 0.
    lft = 24'h800001; rght = 24'h7FFFFE; wrt = 1'b1;
    tick();
    wrt = 1'b0;
    en = 1'b1;
    tick();
    tick();
    check("restart_p0", 48'(w_outs), 48'(6'b000111));
    en = 1'b0;
    frame(1'b0, '0, '0, "f5", b, w);
    check("f5_data", b, W5);
    repeat (10) tick();

    check("rx_count", 48'(rx_q.size()), 48'd4);
    if (rx_q.size() >= 3) begin
      check("rx_f1", rx_q[0], W1);
      check("rx_f2", rx_q[1], FB);
      check("rx_f3", rx_q[2], FB);
    end else begin
      check("rx_short", 48'(rx_q.size()), 48'd3);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
